// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared types and tag constants for bus_arbiter.
// Holds FSM states, Sysbus tag fields and requester ids.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_WAIT,
    ARB_RESP
  } arb_state_t;

  localparam int TAG_W = 13;

  localparam logic TAG_READ = 1'b1;
  localparam logic TAG_WRITE = 1'b0;
  localparam logic [3:0] TAG_MEMORY = 4'h1;

  localparam logic [7:0] ID_I = 8'h00;
  localparam logic [7:0] ID_D = 8'h01;

  function automatic logic [TAG_W-1:0] mk_tag(
    input logic rw,
    input logic [3:0] ty,
    input logic [7:0] id
  );
    return {rw, ty, id};
  endfunction

endpackage

// File: rtl/bus_arb_pick.sv
// bus_arb_pick: two-way grant select (1 = data side wins).
// BUS_ARB_FIXED_PRIO_EN: ties always go to D, no last-grant input.
module bus_arb_pick (
  input  logic i_ireq,
  input  logic i_dreq,
`ifndef BUS_ARB_FIXED_PRIO_EN
  input  logic i_last_d,
`endif
  output logic o_grant_d
);

`ifdef BUS_ARB_FIXED_PRIO_EN
  assign o_grant_d = i_dreq;
`else
  assign o_grant_d = (i_ireq && i_dreq) ? ~i_last_d : i_dreq;
`endif

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: I/D line-fill arbiter onto a single Sysbus port.
// BUS_ARB_FIXED_PRIO_EN selects fixed D priority instead of round-robin.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int BEATS  = 8,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_reqcyc,
  output logic              i_reqack,
  input  logic [ADDR_W-1:0] i_req,
  output logic              i_respcyc,
  output logic [DATA_W-1:0] i_resp,
  input  logic              d_reqcyc,
  output logic              d_reqack,
  input  logic [ADDR_W-1:0] d_req,
  output logic              d_respcyc,
  output logic [DATA_W-1:0] d_resp,
  output logic              bus_reqcyc,
  output logic [ADDR_W-1:0] bus_req,
  output logic [TAG_W-1:0]  bus_reqtag,
  input  logic              bus_reqack,
  input  logic              bus_respcyc,
  input  logic [DATA_W-1:0] bus_resp,
  input  logic [TAG_W-1:0]  bus_resptag,
  output logic              bus_respack,
  output logic              tag_err
);

  localparam int CNT_W = $clog2(BEATS) + 1;

  arb_state_t        r_state;
  logic              r_owner_d;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_bus_reqcyc;
  logic [ADDR_W-1:0] r_bus_req;
  logic [TAG_W-1:0]  r_bus_reqtag;
  logic              r_i_reqack;
  logic              r_d_reqack;
  logic              r_tag_err;
`ifndef BUS_ARB_FIXED_PRIO_EN
  logic              r_last_d;
`endif

  logic              w_grant_d;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_owner_id;
  logic              w_in_resp;
  logic              w_match;
  logic              w_bad;
  logic              w_last;
  logic              w_unused;

  bus_arb_pick u_pick (
    .i_ireq    (i_reqcyc),
    .i_dreq    (d_reqcyc),
`ifndef BUS_ARB_FIXED_PRIO_EN
    .i_last_d  (r_last_d),
`endif
    .o_grant_d (w_grant_d)
  );

  assign w_addr = w_grant_d ? d_req : i_req;
  assign w_owner_id = r_owner_d ? ID_D : ID_I;
  assign w_in_resp = (r_state == ARB_WAIT)
                  || (r_state == ARB_RESP);
  assign w_match = bus_respcyc && w_in_resp
                && (bus_resptag[7:0] == w_owner_id);
  assign w_bad = bus_respcyc && !w_match;
  assign w_last = (r_cnt == CNT_W'(BEATS - 1));
  assign w_unused = ^bus_resptag[TAG_W-1:8];

  assign bus_respack = bus_respcyc;
  assign bus_reqcyc  = r_bus_reqcyc;
  assign bus_req     = r_bus_req;
  assign bus_reqtag  = r_bus_reqtag;
  assign i_reqack    = r_i_reqack;
  assign d_reqack    = r_d_reqack;
  assign tag_err     = r_tag_err;

  assign i_respcyc = w_match && !r_owner_d;
  assign d_respcyc = w_match && r_owner_d;
  assign i_resp    = i_respcyc ? bus_resp : '0;
  assign d_resp    = d_respcyc ? bus_resp : '0;

`ifndef BUS_ARB_FIXED_PRIO_EN
  // Remember the last winner so the next tie flips.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_d <= 1'b1;
    end else if (r_state == ARB_IDLE
              && (i_reqcyc || d_reqcyc)) begin
      r_last_d <= w_grant_d;
    end
  end
`endif

  // Arbitration FSM, beat counter and registered bus outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ARB_IDLE;
      r_owner_d    <= 1'b0;
      r_cnt        <= '0;
      r_bus_reqcyc <= 1'b0;
      r_bus_req    <= '0;
      r_bus_reqtag <= '0;
      r_i_reqack   <= 1'b0;
      r_d_reqack   <= 1'b0;
      r_tag_err    <= 1'b0;
    end else begin
      r_i_reqack <= 1'b0;
      r_d_reqack <= 1'b0;
      if (w_bad) begin
        r_tag_err <= 1'b1;
      end
      unique case (r_state)
        ARB_IDLE: begin
          if (i_reqcyc || d_reqcyc) begin
            r_owner_d    <= w_grant_d;
            r_bus_reqcyc <= 1'b1;
            r_bus_req    <= {w_addr[ADDR_W-1:6], 6'b0};
            r_bus_reqtag <= mk_tag(TAG_READ, TAG_MEMORY,
                              w_grant_d ? ID_D : ID_I);
            r_state      <= ARB_REQ;
          end
        end
        ARB_REQ: begin
          if (bus_reqack) begin
            r_bus_reqcyc <= 1'b0;
            if (r_owner_d) begin
              r_d_reqack <= 1'b1;
            end else begin
              r_i_reqack <= 1'b1;
            end
            r_state <= ARB_WAIT;
          end
        end
        ARB_WAIT, ARB_RESP: begin
          if (w_match) begin
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= ARB_IDLE;
            end else begin
              r_cnt   <= r_cnt + CNT_W'(1);
              r_state <= ARB_RESP;
            end
          end
        end
        default: begin
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: table-driven arbitration rows plus
// hand sequences for gaps, bad tags, late requests and reset.
module tb_bus_arbiter;

  localparam int BEATS = 8;
`ifdef BUS_ARB_FIXED_PRIO_EN
  localparam bit RR = 1'b0;
`else
  localparam bit RR = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        i_reqcyc, i_reqack;
  logic [63:0] i_req;
  logic        i_respcyc;
  logic [63:0] i_resp;
  logic        d_reqcyc, d_reqack;
  logic [63:0] d_req;
  logic        d_respcyc;
  logic [63:0] d_resp;
  logic        bus_reqcyc;
  logic [63:0] bus_req;
  logic [12:0] bus_reqtag;
  logic        bus_reqack;
  logic        bus_respcyc;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;
  logic        bus_respack;
  logic        tag_err;

  bus_arbiter #(
    .BEATS(BEATS), .ADDR_W(64), .DATA_W(64)
  ) dut (
    .clk(clk), .reset(reset),
    .i_reqcyc(i_reqcyc), .i_reqack(i_reqack),
    .i_req(i_req), .i_respcyc(i_respcyc),
    .i_resp(i_resp),
    .d_reqcyc(d_reqcyc), .d_reqack(d_reqack),
    .d_req(d_req), .d_respcyc(d_respcyc),
    .d_resp(d_resp),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req),
    .bus_reqtag(bus_reqtag),
    .bus_reqack(bus_reqack),
    .bus_respcyc(bus_respcyc),
    .bus_resp(bus_resp),
    .bus_resptag(bus_resptag),
    .bus_respack(bus_respack),
    .tag_err(tag_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          d;
    logic [63:0] data;
  } beat_t;

  typedef struct {
    bit          ir;
    bit          dr;
    logic [63:0] ia;
    logic [63:0] da;
    bit          first_d;
  } vec_t;

  beat_t sb[$];
  vec_t  tbl[5];
  int    n_vec = 0;
  int    n_err = 0;
  logic  exp_tag_err = 1'b0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Forwarded beats are checked against the scoreboard.
  always @(negedge clk) begin
    beat_t e;
    chk("respack", bus_respack, bus_respcyc);
    if (i_respcyc || d_respcyc) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL fwd_spurious: i=%b d=%b none expected",
                 i_respcyc, d_respcyc);
      end else begin
        e = sb.pop_front();
        chk("fwd_side", {62'd0, i_respcyc, d_respcyc},
            e.d ? 64'd1 : 64'd2);
        chk("fwd_data", e.d ? d_resp : i_resp, e.data);
      end
    end
  end

  task automatic serve(input bit d,
                       input logic [63:0] a,
                       input int gaps,
                       input bit bad,
                       input bit raise,
                       input logic [63:0] oa);
    int c;
    int hold;
    logic [63:0] dat;
    logic [12:0] tg;
    tg = d ? 13'h1101 : 13'h1100;
    chk("req_idle_entry", bus_reqcyc, 0);
    c = 0;
    do begin
      tick();
      c++;
    end while (!bus_reqcyc && c < 20);
    chk("req_latency", c, 1);
    chk("req_cyc", bus_reqcyc, 1);
    chk("req_addr", bus_req, a & ~64'h3f);
    chk("req_tag", bus_reqtag, tg);
    hold = $urandom_range(0, 2);
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("req_hold_cyc", bus_reqcyc, 1);
      chk("req_hold_addr", bus_req, a & ~64'h3f);
    end
    bus_reqack = 1'b1;
    tick();
    bus_reqack = 1'b0;
    chk("ack_cyc_drop", bus_reqcyc, 0);
    chk("ack_owner", d ? d_reqack : i_reqack, 1);
    chk("ack_other", d ? i_reqack : d_reqack, 0);
    if (d) d_reqcyc = 1'b0;
    else i_reqcyc = 1'b0;
    tick();
    chk("ack_pulse", d ? d_reqack : i_reqack, 0);
    for (int b = 0; b < BEATS; b++) begin
      if (raise && b == 2) begin
        if (d) begin
          i_reqcyc = 1'b1;
          i_req = oa;
        end else begin
          d_reqcyc = 1'b1;
          d_req = oa;
        end
      end
      if (bad && b == 3) begin
        bus_respcyc = 1'b1;
        bus_resptag = 13'h1005;
        bus_resp = {$urandom, $urandom};
        tick();
        bus_respcyc = 1'b0;
        exp_tag_err = 1'b1;
        chk("tag_err_set", tag_err, 1);
      end
      if (b >= 1 && b <= gaps) begin
        tick();
      end
      chk("no_early_req", bus_reqcyc, 0);
      chk("other_noack", d ? i_reqack : d_reqack, 0);
      dat = {$urandom, $urandom};
      bus_respcyc = 1'b1;
      bus_resp = dat;
      bus_resptag = tg;
      sb.push_back('{d, dat});
      tick();
      bus_respcyc = 1'b0;
    end
    chk("sb_drain", sb.size(), 0);
    chk("tag_err", tag_err, exp_tag_err);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    logic [63:0] dat;
    tbl[0] = '{1, 1, 64'h1000_0047, 64'h2000_0088,
               RR ? 1'b0 : 1'b1};
    tbl[1] = '{1, 0, 64'h1234, 64'h0, 1'b0};
    tbl[2] = '{1, 1, 64'h3abc, 64'h4def, 1'b1};
    tbl[3] = '{0, 1, 64'h0, 64'hffff_ffff_ffff_ffff, 1'b1};
    tbl[4] = '{1, 1, 64'h5555_0100, 64'h6666_0200,
               RR ? 1'b0 : 1'b1};

    reset = 1'b0;
    i_reqcyc = 0; i_req = '0;
    d_reqcyc = 0; d_req = '0;
    bus_reqack = 0; bus_respcyc = 0;
    bus_resp = '0; bus_resptag = '0;
    #1 reset = 1'b1;
    bus_respcyc = 1'b1;
    #1;
    chk("rst_bus_reqcyc", bus_reqcyc, 0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_reqtag", bus_reqtag, 0);
    chk("rst_i_reqack", i_reqack, 0);
    chk("rst_d_reqack", d_reqack, 0);
    chk("rst_i_respcyc", i_respcyc, 0);
    chk("rst_d_respcyc", d_respcyc, 0);
    chk("rst_i_resp", i_resp, 0);
    chk("rst_d_resp", d_resp, 0);
    chk("rst_tag_err", tag_err, 0);
    chk("rst_respack", bus_respack, 1);
    bus_respcyc = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      i_reqcyc = tbl[i].ir;
      i_req = tbl[i].ia;
      d_reqcyc = tbl[i].dr;
      d_req = tbl[i].da;
      serve(tbl[i].first_d,
            tbl[i].first_d ? tbl[i].da : tbl[i].ia,
            i % 3, 0, 0, 64'h0);
      if (tbl[i].ir && tbl[i].dr) begin
        serve(~tbl[i].first_d,
              tbl[i].first_d ? tbl[i].ia : tbl[i].da,
              1, 0, 0, 64'h0);
      end
    end

    i_reqcyc = 1'b1;
    i_req = 64'h5000;
    serve(0, 64'h5000, 3, 0, 1, 64'h6000_0010);
    serve(1, 64'h6000_0010, 0, 1, 1, 64'h7000);
    serve(0, 64'h7000, 2, 0, 0, 64'h0);

    i_reqcyc = 1'b1;
    i_req = 64'h8000_0000;
    c = 0;
    do begin
      tick();
      c++;
    end while (!bus_reqcyc && c < 20);
    chk("mid_req_cyc", bus_reqcyc, 1);
    bus_reqack = 1'b1;
    tick();
    bus_reqack = 1'b0;
    i_reqcyc = 1'b0;
    for (int b = 0; b < 3; b++) begin
      dat = {$urandom, $urandom};
      bus_respcyc = 1'b1;
      bus_resp = dat;
      bus_resptag = 13'h1100;
      sb.push_back('{0, dat});
      tick();
      bus_respcyc = 1'b0;
    end
    chk("mid_sb_drain", sb.size(), 0);
    bus_respcyc = 1'b1;
    bus_resp = 64'hdead_beef_0000_0001;
    bus_resptag = 13'h1100;
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_i_respcyc", i_respcyc, 0);
    chk("mid_rst_i_resp", i_resp, 0);
    chk("mid_rst_reqcyc", bus_reqcyc, 0);
    chk("mid_rst_tag_err", tag_err, 0);
    chk("mid_rst_respack", bus_respack, 1);
    tick();
    bus_respcyc = 1'b0;
    tick();
    reset = 1'b0;
    exp_tag_err = 1'b0;
    chk("post_rst_i_reqack", i_reqack, 0);
    i_reqcyc = 1'b1;
    i_req = 64'h9000_0123;
    serve(0, 64'h9000_0123, 1, 0, 0, 64'h0);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
